// File: rtl/croc_sram_interleaver_pkg.sv
// croc_sram_interleaver_pkg
// Shared types, constants and the address-mapping function for the Croc SRAM
// region front end. The mapping function lives here so the crossbar rule
// generator, the RTL and the testbench all agree on where a word goes.
package croc_sram_interleaver_pkg;

    localparam int unsigned ObiIdWidth        = 4;
    localparam int unsigned SramNumBanks      = 2;
    localparam int unsigned SramBankNumWords  = 512;
    localparam logic [31:0] SramBaseAddr      = 32'h1000_0000;
    localparam bit          SramInterleaved   = 1'b1;
    localparam int unsigned SramBankAddrWidth = $clog2(SramBankNumWords);

    typedef enum logic [1:0] {
        START,
        INIT,
        IDLE
    } sram_state_e;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [3:0]            be;
        logic [31:0]           addr;
        logic [31:0]           wdata;
        logic [ObiIdWidth-1:0] aid;
    } sbr_obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [31:0]           rdata;
        logic [ObiIdWidth-1:0] rid;
        logic                  err;
    } sbr_obi_rsp_t;

    // Bank and row are kept 32 bits wide so one struct serves any geometry;
    // users slice them down to their own index widths.
    typedef struct packed {
        logic        oob;
        logic [31:0] bank;
        logic [31:0] row;
    } sram_map_t;

    // Maps a byte address onto (bank, row). The region size is computed on
    // 33 bits so a region ending exactly at 4 GiB does not wrap to zero.
    function automatic sram_map_t sram_map(
        input logic [31:0] addr,
        input logic        interleaved,
        input logic [31:0] base_addr      = SramBaseAddr,
        input int unsigned num_banks      = SramNumBanks,
        input int unsigned bank_num_words = SramBankNumWords
    );
        sram_map_t   m;
        logic [31:0] offset;
        logic [31:0] w;
        logic [32:0] size;
        offset = addr - base_addr;
        w      = offset >> 2;
        size   = 33'(num_banks) * 33'(bank_num_words) * 33'd4;
        m.oob  = (addr < base_addr) || ({1'b0, offset} >= size);
        if (interleaved) begin
            m.bank = w % num_banks;
            m.row  = w / num_banks;
        end else begin
            m.bank = w / bank_num_words;
            m.row  = w % bank_num_words;
        end
        return m;
    endfunction

endpackage

// File: rtl/croc_sram_interleaver.sv
// croc_sram_interleaver
// Single OBI subordinate port in front of NumBanks single-port SRAM banks.
// After reset (or on init_req_i) every bank is swept with zero writes before
// any request is granted; afterwards requests are granted combinationally and
// answered one cycle later.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   obi_req_i/_rsp_o   OBI request from / response to the crossbar
//   init_req_i         pulse: start a re-initialisation sweep (IDLE only)
//   init_busy_o        high while a sweep is pending or running
//   bank_*_o           per-bank chip enable, write enable, row, data, strobes
//   bank_rdata_i       per-bank read data, valid one cycle after the request
module croc_sram_interleaver
    import croc_sram_interleaver_pkg::*;
#(
    parameter int unsigned NumBanks     = SramNumBanks,
    parameter int unsigned BankNumWords = SramBankNumWords,
    parameter logic [31:0] BaseAddr     = SramBaseAddr,
    parameter bit          Interleaved  = SramInterleaved,
    localparam int unsigned BankAddrWidth = (BankNumWords > 1) ? $clog2(BankNumWords) : 1,
    localparam int unsigned BankIdxWidth  = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  sbr_obi_req_t                           obi_req_i,
    output sbr_obi_rsp_t                           obi_rsp_o,
    input  logic                                   init_req_i,
    output logic                                   init_busy_o,
    output logic [NumBanks-1:0]                    bank_req_o,
    output logic [NumBanks-1:0]                    bank_we_o,
    output logic [NumBanks-1:0][BankAddrWidth-1:0] bank_addr_o,
    output logic [NumBanks-1:0][31:0]              bank_wdata_o,
    output logic [NumBanks-1:0][3:0]               bank_be_o,
    input  logic [NumBanks-1:0][31:0]              bank_rdata_i
);

    localparam logic [BankAddrWidth-1:0] LastRow = BankAddrWidth'(BankNumWords - 1);

    sram_state_e              state_q, state_d;
    logic [BankAddrWidth-1:0] row_q, row_d;

    sram_map_t                map;
    logic [BankIdxWidth-1:0]  sel_bank;
    logic [BankAddrWidth-1:0] sel_row;
    logic                     map_unused;
    logic                     gnt;

    logic                     rvalid_q;
    logic                     read_q;
    logic                     err_q;
    logic [ObiIdWidth-1:0]    rid_q;
    logic [BankIdxWidth-1:0]  bank_q;

    assign map      = sram_map(obi_req_i.addr, Interleaved, BaseAddr, NumBanks, BankNumWords);
    assign sel_bank = map.bank[BankIdxWidth-1:0];
    assign sel_row  = map.row[BankAddrWidth-1:0];
    // Upper bits of the generic mapping result are zero for in-range
    // addresses and irrelevant otherwise.
    assign map_unused = ^{map.bank, map.row};

    // State register and sweep row counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= START;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Next-state logic: START always lasts one cycle, INIT walks every row,
    // and only IDLE honours a re-init request so a running sweep never restarts.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        unique case (state_q)
            START: begin
                state_d = INIT;
                row_d   = '0;
            end
            INIT: begin
                if (row_q == LastRow) begin
                    state_d = IDLE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            IDLE: begin
                if (init_req_i) begin
                    state_d = START;
                end
            end
            default: state_d = START;
        endcase
    end

    // Bank drive and grant: the sweep writes zeros to all banks in parallel;
    // in IDLE only the decoded bank is touched, and out-of-range requests are
    // granted without any bank access so they can be answered with err.
    always_comb begin
        bank_req_o   = '0;
        bank_we_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        gnt          = 1'b0;
        unique case (state_q)
            INIT: begin
                bank_req_o = '1;
                bank_we_o  = '1;
                bank_be_o  = '1;
                for (int i = 0; i < int'(NumBanks); i++) begin
                    bank_addr_o[i] = row_q;
                end
            end
            IDLE: begin
                gnt = obi_req_i.req;
                if (obi_req_i.req && !map.oob) begin
                    bank_req_o[sel_bank]   = 1'b1;
                    bank_we_o[sel_bank]    = obi_req_i.we;
                    bank_addr_o[sel_bank]  = sel_row;
                    bank_wdata_o[sel_bank] = obi_req_i.wdata;
                    bank_be_o[sel_bank]    = obi_req_i.be;
                end
            end
            default: ;
        endcase
    end

    // Response register: remembers which bank to pick read data from, since
    // the SRAM returns data one cycle after the request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            read_q   <= 1'b0;
            err_q    <= 1'b0;
            rid_q    <= '0;
            bank_q   <= '0;
        end else begin
            rvalid_q <= gnt;
            read_q   <= gnt && !obi_req_i.we && !map.oob;
            if (gnt) begin
                rid_q  <= obi_req_i.aid;
                err_q  <= map.oob;
                bank_q <= sel_bank;
            end
        end
    end

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = gnt;
        obi_rsp_o.rvalid = rvalid_q;
        obi_rsp_o.rid    = rid_q;
        obi_rsp_o.err    = err_q;
        obi_rsp_o.rdata  = read_q ? bank_rdata_i[bank_q] : 32'h0;
    end

    assign init_busy_o = (state_q != IDLE);

endmodule

// File: doc/croc_sram_interleaver.md
# croc_sram_interleaver

Parametrised OBI-subordinate front end for the Croc SRAM region. It replaces the fixed one-crossbar-port-per-bank arrangement with a single crossbar port. It maps each request onto `NumBanks` single-port SRAM banks using either contiguous or word-interleaved addressing, and returns the response one cycle later. It also contains a zero-initialisation engine that sweeps every bank after reset or on request, so software never reads undefined SRAM.

## Interface
Parameters:
- `NumBanks`, default 2: number of SRAM banks. Must be a power of two and at least 1.
- `BankNumWords`, default 512: 32-bit words per bank. Must be a power of two.
- `BaseAddr`, default 32'h1000_0000: first byte address of the region.
- `Interleaved`, default 1'b1: selects addressing. 1 means word-interleaved; 0 means contiguous.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `obi_req_i` in `sbr_obi_req_t`: OBI request from the crossbar.
- `obi_rsp_o` out `sbr_obi_rsp_t`: OBI response to the crossbar.
- `init_req_i` in 1: single-cycle pulse that starts a re-initialisation sweep.
- `init_busy_o` out 1: high while a sweep is pending or running.
- `bank_req_o` out `NumBanks`: per-bank chip enable.
- `bank_we_o` out `NumBanks`: per-bank write enable.
- `bank_addr_o` out `NumBanks` x `BankAddrWidth`: row address. `BankAddrWidth` = clog2(`BankNumWords`).
- `bank_wdata_o` out `NumBanks` x 32: write data.
- `bank_be_o` out `NumBanks` x 4: byte enables.
- `bank_rdata_i` in `NumBanks` x 32: read data, valid one cycle after the bank request.

## Operation
- Address decode:
  - Word address `w` = (`addr` − `BaseAddr`) >> 2.
  - Region size is `NumBanks`·`BankNumWords`·4 bytes.
  - An address is out of range when `addr` < `BaseAddr` or `addr` ≥ `BaseAddr` + region size. Unsigned arithmetic; any subtraction underflow counts as out of range.
- Interleaved mode: bank = `w` mod `NumBanks`; row = `w` / `NumBanks`.
- Contiguous mode: bank = `w` / `BankNumWords`; row = `w` mod `BankNumWords`.
- States:
  - START: reset state, lasts one cycle. No bank access and no grant. Next state is INIT.
  - INIT: counter `row` runs from 0 to `BankNumWords`−1. Every bank sees `req`=1, `we`=1, `be`=4'hF, `wdata`=0 and `addr`=`row`.
    - `gnt`=0 throughout.
    - After `row`=`BankNumWords`−1, go to IDLE.
  - IDLE: `gnt` = `req`, combinationally.
    - An in-range request drives only the selected bank with `addr`, `we`, `be` and `wdata`.
    - An out-of-range request is granted but drives no bank.
- `init_req_i` handling:
  - In IDLE: next state is START. A request granted in that same cycle still completes normally.
  - In START or INIT: ignored; the running sweep is not restarted.
- Response:
  - On every grant, register `rvalid`=1, `rid`=`aid`, `err`=out-of-range, and the selected bank index.
  - Next cycle: `rdata` = `bank_rdata_i`[selected bank] for an in-range read; otherwise 0.
  - Writes also produce `rvalid` with `rdata`=0.
- `init_busy_o` = (state ≠ IDLE).

## Timing
- While `rst_ni` is low:
  - State is START, `row`=0.
  - `obi_rsp_o` is all zero.
  - `bank_req_o`=0, `bank_we_o`=0.
  - `init_busy_o`=1.
- Time from reset release to the first grant is exactly 1 + `BankNumWords` cycles.
- Grant latency in IDLE is 0 cycles. Response latency is 1 cycle. Back-to-back requests are accepted one per cycle with no bubbles.
- If `rst_ni` asserts mid-sweep or mid-response: the sweep restarts from START and the pending `rvalid` is dropped.
- Boundary addresses:
  - The last word of the region maps to bank `NumBanks`−1, row `BankNumWords`−1 in both modes.
  - The first byte past the region gives `err`=1.

## Structure
- Add to `croc_pkg`:
  - `SramInterleaved` localparam.
  - `SramBankAddrWidth`, reused as `BankAddrWidth`.
  - `sram_state_e` enum {START, INIT, IDLE}.
  - Pure function `sram_map(addr, interleaved)`, returning a struct {`oob`, `bank`, `row`}, so the crossbar rule generator and testbench share one mapping.
- No sub-module is required. The init sweep and the response register stay inline.

## Test plan
Settings unless stated: `NumBanks`=2, `BankNumWords`=512, `Interleaved`=1.

- Reset release -> `init_busy_o` stays high for exactly 513 cycles. Every bank sees 512 zero-writes at rows 0..511. A read of 0x1000_03FC afterwards -> `rdata`=0, `err`=0.
- Write 0xDEADBEEF to 0x1000_0004, then read 0x1000_0008:
  - The write hits bank 1, row 0.
  - The read hits bank 0, row 1.
  - Reading 0x1000_0004 -> `rdata`=0xDEADBEEF one cycle after grant.
- `Interleaved`=0, write to 0x1000_0800 -> bank 1, row 0. Write to 0x1000_07FC -> bank 0, row 511.
- Read 0x1000_1000, then 0x0FFF_FFFC -> both granted, no `bank_req_o`, response `err`=1, `rdata`=0, `rid` echoes `aid`.
- Back-to-back reads with `aid`=2 then `aid`=5 -> consecutive `rvalid` cycles, `rid` 2 then 5, correct per-bank data.
- Pulse `init_req_i` in the same cycle as a granted read -> the read response is returned next cycle. Then a 513-cycle sweep runs and previously written data reads back 0. A second pulse mid-sweep does not extend the sweep.
